// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the sequential square root.
// Sizing functions take WIDTH/R so each instance derives its own widths.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int res;
      int x;
      res = 0;
      x = 1;
      while (x < v) begin
         x = x * 2;
         res = res + 1;
      end
      return res;
   endfunction

   function automatic int n_steps(input int width, input int r);
      return width / (2 * r);
   endfunction

   function automatic int rem_w(input int width);
      return width / 2 + 2;
   endfunction

   function automatic int cnt_w(input int width, input int r);
      return clog2(n_steps(width, r) + 1);
   endfunction

   localparam int DEF_WIDTH = 16;
   localparam int DEF_R     = 1;
   localparam int DEF_N     = n_steps(DEF_WIDTH, DEF_R);
   localparam int DEF_CNT_W = cnt_w(DEF_WIDTH, DEF_R);
   localparam int DEF_REM_W = rem_w(DEF_WIDTH);

endpackage

// File: rtl/sqrt_rem_step.sv
// One restoring square-root digit step: consumes two radicand bits,
// resolves one root bit.
module sqrt_rem_step
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH/2+1:0] r,
   input  logic [WIDTH/2-1:0] q,
   input  logic [1:0]         bits,
   output logic [WIDTH/2+1:0] r_nxt,
   output logic [WIDTH/2-1:0] q_nxt
);

   localparam int QW = WIDTH / 2;
   localparam int RW = rem_w(WIDTH);

   logic [RW+1:0] rs;
   logic [RW+1:0] t;
   logic          ge;

   // Shift in the next bit pair, try subtracting 4q+1, keep if non-negative.
   always_comb begin
      rs    = {r, bits};
      t     = {2'b00, q, 2'b01};
      ge    = (rs >= t);
      r_nxt = ge ? RW'(rs - t) : RW'(rs);
      q_nxt = QW'({q, ge});
   end

endmodule

// File: rtl/sqrt_rem_seq.sv
// Multi-cycle integer square root with floor remainder and optional
// round-to-nearest; R root bits per cycle, valid/ready on both sides.
module sqrt_rem_seq
   import sqrt_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int R     = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic               in_round,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH/2-1:0] out_root,
   output logic [WIDTH/2:0]   out_rem,
   output logic               out_rnd_up,
   output logic               out_sat
);

   localparam int QW = WIDTH / 2;
   localparam int RW = rem_w(WIDTH);
   localparam int N  = n_steps(WIDTH, R);
   localparam int CW = cnt_w(WIDTH, R);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [WIDTH-1:0] a_sh;
   logic            rnd;
   logic [QW-1:0]   q;
   logic [RW-1:0]   r;
   logic            last;

   logic [RW-1:0]   r_c [0:R];
   logic [QW-1:0]   q_c [0:R];

   logic [QW-1:0]   root_fin;
   logic            up_fin;
   logic            sat_fin;

   assign in_ready = (state == IDLE);
   assign last     = (cnt == LAST);
   assign r_c[0]   = r;
   assign q_c[0]   = q;

   genvar g;
   generate
      for (g = 0; g < R; g++) begin : g_step
         sqrt_rem_step #(
            .WIDTH(WIDTH)
         ) u_step (
            .r    (r_c[g]),
            .q    (q_c[g]),
            .bits (a_sh[WIDTH-1-2*g -: 2]),
            .r_nxt(r_c[g+1]),
            .q_nxt(q_c[g+1])
         );
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (in_valid)              state_nxt = CALC;
         CALC: if (last)                  state_nxt = DONE;
         DONE: if (out_valid && out_ready) state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
   end

   // Round-to-nearest on the final step result; saturate at all-ones.
   always_comb begin
      root_fin = q_c[R];
      up_fin   = 1'b0;
      sat_fin  = 1'b0;
      if (rnd && (r_c[R] > {{(RW-QW){1'b0}}, q_c[R]})) begin
         if (&q_c[R]) begin
            sat_fin = 1'b1;
         end else begin
            root_fin = q_c[R] + 1'b1;
            up_fin   = 1'b1;
         end
      end
   end

   // Datapath: operand capture, iteration, and result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         a_sh       <= '0;
         rnd        <= 1'b0;
         q          <= '0;
         r          <= '0;
         out_valid  <= 1'b0;
         out_root   <= '0;
         out_rem    <= '0;
         out_rnd_up <= 1'b0;
         out_sat    <= 1'b0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            a_sh <= in_a;
            rnd  <= in_round;
            q    <= '0;
            r    <= '0;
            cnt  <= '0;
         end
      end else if (state == CALC) begin
         a_sh <= a_sh << (2 * R);
         q    <= q_c[R];
         r    <= r_c[R];
         cnt  <= cnt + 1'b1;
         if (last) begin
            out_valid  <= 1'b1;
            out_root   <= root_fin;
            out_rem    <= r_c[R][QW:0];
            out_rnd_up <= up_fin;
            out_sat    <= sat_fin;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sqrt_rem_seq.sv
// Directed and swept checks of sqrt_rem_seq at several WIDTH/R points.
// Shared 16-bit stimulus drives R=1, R=4 and R=8 instances together.
module tb_sqrt_rem_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        in_valid = 1'b0;
   logic [15:0] in_a = '0;
   logic        in_round = 1'b0;
   logic        out_ready = 1'b0;

   logic       ir0, ov0, up0, sat0;
   logic [7:0] root0;
   logic [8:0] rem0;
   logic       ir2, ov2, up2, sat2;
   logic [7:0] root2;
   logic [8:0] rem2;
   logic       ir3, ov3, up3, sat3;
   logic [7:0] root3;
   logic [8:0] rem3;

   logic        in_valid1 = 1'b0;
   logic [31:0] in_a1 = '0;
   logic        in_round1 = 1'b0;
   logic        out_ready1 = 1'b0;
   logic        ir1, ov1, up1, sat1;
   logic [15:0] root1;
   logic [16:0] rem1;

   sqrt_rem_seq #(.WIDTH(16), .R(1)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
      .in_a(in_a), .in_round(in_round), .out_valid(ov0),
      .out_ready(out_ready), .out_root(root0), .out_rem(rem0),
      .out_rnd_up(up0), .out_sat(sat0));

   sqrt_rem_seq #(.WIDTH(16), .R(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2),
      .in_a(in_a), .in_round(in_round), .out_valid(ov2),
      .out_ready(out_ready), .out_root(root2), .out_rem(rem2),
      .out_rnd_up(up2), .out_sat(sat2));

   sqrt_rem_seq #(.WIDTH(16), .R(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir3),
      .in_a(in_a), .in_round(in_round), .out_valid(ov3),
      .out_ready(out_ready), .out_root(root3), .out_rem(rem3),
      .out_rnd_up(up3), .out_sat(sat3));

   sqrt_rem_seq #(.WIDTH(32), .R(2)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(ir1),
      .in_a(in_a1), .in_round(in_round1), .out_valid(ov1),
      .out_ready(out_ready1), .out_root(root1), .out_rem(rem1),
      .out_rnd_up(up1), .out_sat(sat1));

   typedef struct {
      logic [15:0] a;
      logic        rnd;
      int          root;
      int          rem;
      logic        up;
      logic        sat;
   } vec_t;

   typedef struct {
      int  root;
      int  rem;
      logic up;
      logic sat;
   } res_t;

   task automatic chk(input string name, input longint got, input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   function automatic res_t model(input longint a, input logic rnd, input int qw);
      res_t   res;
      longint f;
      longint rm;
      longint mx;
      f = 0;
      while ((f + 1) * (f + 1) <= a) f++;
      rm = a - f * f;
      mx = (longint'(1) << qw) - 1;
      res.root = int'(f);
      res.rem  = int'(rm);
      res.up   = 1'b0;
      res.sat  = 1'b0;
      if (rnd && rm > f) begin
         if (f == mx) res.sat = 1'b1;
         else begin
            res.root = int'(f + 1);
            res.up   = 1'b1;
         end
      end
      return res;
   endfunction

   // Offer one radicand to the 16-bit group; wait (bounded) until all hold valid.
   task automatic start16(input logic [15:0] a, input logic rnd, output int lat0,
                          output int lat2, output int lat3);
      @(negedge clk);
      in_a = a;
      in_round = rnd;
      in_valid = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      lat0 = -1;
      lat2 = -1;
      lat3 = -1;
      for (int c = 1; c <= 20; c++) begin
         if (ov0 && lat0 < 0) lat0 = c - 1;
         if (ov2 && lat2 < 0) lat2 = c - 1;
         if (ov3 && lat3 < 0) lat3 = c - 1;
         if (lat0 >= 0 && lat2 >= 0 && lat3 >= 0) break;
         @(negedge clk);
      end
      if (lat0 < 0 || lat2 < 0 || lat3 < 0) chk("timeout16", 0, 1);
   endtask

   task automatic release16;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic cmp16(input string tag, input res_t e);
      chk({tag, " root0"}, root0, e.root);
      chk({tag, " rem0"}, rem0, e.rem);
      chk({tag, " up0"}, up0, e.up);
      chk({tag, " sat0"}, sat0, e.sat);
      chk({tag, " root2"}, root2, e.root);
      chk({tag, " rem2"}, rem2, e.rem);
      chk({tag, " flags2"}, {up2, sat2}, {e.up, e.sat});
      chk({tag, " root3"}, root3, e.root);
      chk({tag, " rem3"}, rem3, e.rem);
      chk({tag, " flags3"}, {up3, sat3}, {e.up, e.sat});
   endtask

   task automatic run32(input logic [31:0] a, input logic rnd, input res_t e,
                        input string tag);
      int lat;
      @(negedge clk);
      in_a1 = a;
      in_round1 = rnd;
      in_valid1 = 1'b1;
      out_ready1 = 1'b0;
      @(negedge clk);
      in_valid1 = 1'b0;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (ov1) begin
            lat = c;
            break;
         end
      end
      chk({tag, " lat32"}, lat, 8);
      chk({tag, " root32"}, root1, e.root);
      chk({tag, " rem32"}, rem1, e.rem);
      chk({tag, " flags32"}, {up1, sat1}, {e.up, e.sat});
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
   endtask

   vec_t vecs[12];

   initial begin
      int   l0, l2, l3;
      res_t e;
      logic [15:0] ra;
      logic [31:0] ra32;
      logic        rr;

      vecs[0]  = '{16'd0,     1'b0, 0,   0,   1'b0, 1'b0};
      vecs[1]  = '{16'd200,   1'b0, 14,  4,   1'b0, 1'b0};
      vecs[2]  = '{16'd210,   1'b1, 14,  14,  1'b0, 1'b0};
      vecs[3]  = '{16'd211,   1'b1, 15,  15,  1'b1, 1'b0};
      vecs[4]  = '{16'd65535, 1'b1, 255, 510, 1'b0, 1'b1};
      vecs[5]  = '{16'd65535, 1'b0, 255, 510, 1'b0, 1'b0};
      vecs[6]  = '{16'd144,   1'b0, 12,  0,   1'b0, 1'b0};
      vecs[7]  = '{16'd1,     1'b1, 1,   0,   1'b0, 1'b0};
      vecs[8]  = '{16'd2,     1'b1, 1,   1,   1'b0, 1'b0};
      vecs[9]  = '{16'd3,     1'b1, 2,   2,   1'b1, 1'b0};
      vecs[10] = '{16'd99,    1'b1, 10,  18,  1'b1, 1'b0};
      vecs[11] = '{16'd65025, 1'b1, 255, 0,   1'b0, 1'b0};

      // Reset state.
      @(negedge clk);
      chk("rst out_valid", ov0, 0);
      chk("rst in_ready", ir0, 1);
      chk("rst root", root0, 0);
      chk("rst rem", rem0, 0);
      chk("rst flags", {up0, sat0}, 0);
      rst = 1'b0;

      // Table vectors across R=1/4/8.
      for (int i = 0; i < 12; i++) begin
         start16(vecs[i].a, vecs[i].rnd, l0, l2, l3);
         if (i == 0) begin
            chk("lat r1", l0, 8);
            chk("lat r4", l2, 2);
            chk("lat r8", l3, 1);
         end
         e.root = vecs[i].root;
         e.rem  = vecs[i].rem;
         e.up   = vecs[i].up;
         e.sat  = vecs[i].sat;
         cmp16($sformatf("vec%0d", i), e);
         release16();
      end

      // Random sweep against the reference model.
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rr = 1'($urandom);
         start16(ra, rr, l0, l2, l3);
         cmp16($sformatf("rnd%0d", i), model(ra, rr, 8));
         release16();
      end

      // WIDTH=32, R=2.
      run32(32'd1000000, 1'b0, model(1000000, 1'b0, 16), "w32 1e6");
      run32(32'hFFFF_FFFF, 1'b1, model(32'hFFFF_FFFF, 1'b1, 16), "w32 max");
      for (int i = 0; i < 8; i++) begin
         ra32 = $urandom;
         rr = 1'($urandom);
         run32(ra32, rr, model(ra32, rr, 16), $sformatf("w32 rnd%0d", i));
      end

      // Backpressure: result held, extra offers ignored.
      start16(16'd200, 1'b0, l0, l2, l3);
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1;
         in_a = 16'(c * 1000 + 7);
         @(negedge clk);
         chk("bp valid", ov0, 1);
         chk("bp root", root0, 14);
         chk("bp rem", rem0, 4);
         chk("bp in_ready", ir0, 0);
      end
      in_valid = 1'b0;
      release16();
      chk("bp released valid", ov0, 0);
      chk("bp released ready", ir0, 1);
      repeat (10) @(negedge clk);
      chk("bp no queued result", ov0, 0);

      // Abort mid-CALC.
      in_a = 16'd300;
      in_round = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("abort valid", ov0, 0);
      chk("abort root", root0, 0);
      chk("abort rem", rem0, 0);
      chk("abort flags", {up0, sat0}, 0);
      chk("abort in_ready", ir0, 1);
      @(negedge clk);
      rst = 1'b0;
      start16(16'd144, 1'b0, l0, l2, l3);
      chk("post-abort lat", l0, 8);
      chk("post-abort root", root0, 12);
      chk("post-abort rem", rem0, 0);
      release16();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
